// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Purpose  : Shared types and constants for the interrupt arbiter slice.
//            irq_state_t        - arbiter FSM state encoding
//            IRQ_N_SRC_DEFAULT  - default number of interrupt sources
// Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam int IRQ_N_SRC_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Returns the first set bit of
//            elig_i searched from rr_ptr_i upward, wrapping modulo N.
// Ports    : elig_i   [N]    candidate vector
//            rr_ptr_i [ID_W] search start position (must be < N)
//            pick_o   [ID_W] index of the selected candidate
//            valid_o         high when any candidate is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    elig_i,
  input  logic [ID_W-1:0] rr_ptr_i,
  output logic [ID_W-1:0] pick_o,
  output logic            valid_o
);

  int w_dist;
  int w_best_dist;

  // Each candidate is ranked by its circular distance from the pointer;
  // the smallest distance among set bits wins.
  always_comb begin
    valid_o     = 1'b0;
    pick_o      = '0;
    w_dist      = 0;
    w_best_dist = N;
    for (int j = 0; j < N; j++) begin
      w_dist = j - int'(rr_ptr_i);
      if (w_dist < 0) begin
        w_dist = w_dist + N;
      end
      if (elig_i[j] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        pick_o      = ID_W'(j);
        valid_o     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : irq_arbiter
// Purpose  : Collects level interrupt requests, arbitrates round-robin,
//            drives a registered ExtIRQ to the controller and follows the
//            ExcAck / ERet exception handshake. Issues a one-cycle one-hot
//            acknowledge to the serviced source.
// Ports    : clk        system clock
//            reset      asynchronous active-low reset
//            irq_req    [N_SRC] level requests
//            ExtIRQ     registered interrupt request to controller
//            ExcAck     exception taken by datapath
//            ERet       handler return
//            irq_ack    [N_SRC] one-cycle one-hot acknowledge
//            irq_id     [ID_W]  granted / in-service source id
//            busy       high while in REQ or SERVICE
// Option   : IRQ_ARBITER_MASK_EN adds mask_we, mask_wdata[N_SRC], mask[N_SRC]
//            (mask resets to all-ones; a set bit blocks arbitration only).
// Revision : 1.0 - initial release
// ============================================================================
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int N_SRC = IRQ_N_SRC_DEFAULT,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_req,
  output logic             ExtIRQ,
  input  logic             ExcAck,
  input  logic             ERet,
  output logic [N_SRC-1:0] irq_ack,
  output logic [ID_W-1:0]  irq_id,
  output logic             busy
`ifdef IRQ_ARBITER_MASK_EN
  ,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask
`endif
);

  irq_state_t       state_q,   state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [ID_W-1:0]  rr_ptr_q,  rr_ptr_d;
  logic [ID_W-1:0]  irq_id_q,  irq_id_d;
  logic             ext_q,     ext_d;
  logic [N_SRC-1:0] ack_q,     ack_d;

  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] id_onehot;
  logic [ID_W-1:0]  pick;
  logic             pick_valid;

`ifdef IRQ_ARBITER_MASK_EN
  logic [N_SRC-1:0] mask_q;

  // The mask only gates entry into arbitration, so rewriting it while a
  // grant is outstanding leaves that grant untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '1;
    end else if (mask_we) begin
      mask_q <= mask_wdata;
    end
  end

  assign mask = mask_q;
  assign elig = pending_q & ~mask_q;
`else
  assign elig = pending_q;
`endif

  rr_pick #(
    .N    (N_SRC),
    .ID_W (ID_W)
  ) u_rr_pick (
    .elig_i   (elig),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (pick),
    .valid_o  (pick_valid)
  );

  assign id_onehot = {{(N_SRC-1){1'b0}}, 1'b1} << irq_id_q;

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    ext_d    = ext_q;
    ack_d    = '0;
    rr_ptr_d = rr_ptr_q;
    clr      = '0;
    case (state_q)
      IDLE: begin
        // Arbitration uses the registered pending vector, so a request
        // arriving alongside a decision waits for the next one.
        if (pick_valid) begin
          irq_id_d = pick;
          ext_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        // ExcAck has priority; ERet is meaningless before the exception.
        if (ExcAck) begin
          ext_d   = 1'b0;
          ack_d   = id_onehot;
          clr     = id_onehot;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (ERet) begin
          rr_ptr_d = (irq_id_q == ID_W'(N_SRC - 1)) ? '0 : irq_id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ext_d   = 1'b0;
      end
    endcase
    // Clear beats a simultaneous set; a held request re-arms next cycle.
    pending_d = (pending_q | irq_req) & ~clr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      irq_id_q  <= '0;
      ext_q     <= 1'b0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      irq_id_q  <= irq_id_d;
      ext_q     <= ext_d;
      ack_q     <= ack_d;
    end
  end

  assign ExtIRQ  = ext_q;
  assign irq_ack = ack_q;
  assign irq_id  = irq_id_q;
  assign busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_arbiter
// Purpose  : Directed self-checking bench for irq_arbiter (N_SRC = 4).
//            Covers the optional mask port set when IRQ_ARBITER_MASK_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    irq_req;
  logic            ExtIRQ;
  logic            ExcAck;
  logic            ERet;
  logic [N-1:0]    irq_ack;
  logic [ID_W-1:0] irq_id;
  logic            busy;
`ifdef IRQ_ARBITER_MASK_EN
  logic            mask_we;
  logic [N-1:0]    mask_wdata;
  logic [N-1:0]    mask;
`endif

  int n_vec = 0;
  int n_err = 0;

  irq_arbiter #(.N_SRC(N), .ID_W(ID_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_req (irq_req),
    .ExtIRQ  (ExtIRQ),
    .ExcAck  (ExcAck),
    .ERet    (ERet),
    .irq_ack (irq_ack),
    .irq_id  (irq_id),
    .busy    (busy)
`ifdef IRQ_ARBITER_MASK_EN
    ,
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then clear the mask on the first edge after release so that all
  // sources are eligible; the caller sets irq_req beforehand.
  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
`ifdef IRQ_ARBITER_MASK_EN
    mask_we    = 1'b1;
    mask_wdata = '0;
`endif
    reset = 1'b1;
    tick();
`ifdef IRQ_ARBITER_MASK_EN
    mask_we = 1'b0;
`endif
  endtask

  task automatic wait_ext(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!ExtIRQ && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, 32'(ExtIRQ), 32'd1);
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset   = 1'b0;
    irq_req = 4'b0101;
    ExcAck  = 1'b0;
    ERet    = 1'b0;
`ifdef IRQ_ARBITER_MASK_EN
    mask_we    = 1'b0;
    mask_wdata = '0;
`endif

    // ---- reset held with requests present --------------------------------
    tick();
    chk("rst_ext",  32'(ExtIRQ),  32'd0);
    chk("rst_ack",  32'(irq_ack), 32'd0);
    chk("rst_busy", 32'(busy),    32'd0);
    chk("rst_id",   32'(irq_id),  32'd0);
    tick();
    chk("rst_ext2", 32'(ExtIRQ),  32'd0);
`ifdef IRQ_ARBITER_MASK_EN
    mask_we    = 1'b1;
    mask_wdata = '0;
`endif
    reset = 1'b1;
    tick();                        // pending captures 0101
`ifdef IRQ_ARBITER_MASK_EN
    mask_we = 1'b0;
`endif
    tick();                        // arbitration from rr_ptr 0
    chk("rel_ext",  32'(ExtIRQ), 32'd1);
    chk("rel_id",   32'(irq_id), 32'd0);
    chk("rel_busy", 32'(busy),   32'd1);

    // ---- single pulse, late ExcAck ---------------------------------------
    irq_req = '0;
    do_reset();
    irq_req = 4'b0100;
    tick();                        // pulse captured in pending
    irq_req = '0;
    chk("p_ext_pre", 32'(ExtIRQ), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("p_ext_hold", 32'(ExtIRQ), 32'd1);
      chk("p_id_hold",  32'(irq_id), 32'd2);
    end
    ExcAck = 1'b1;
    tick();
    ExcAck = 1'b0;
    chk("p_ack",      32'(irq_ack), 32'h4);
    chk("p_ext_lo",   32'(ExtIRQ),  32'd0);
    chk("p_id_svc",   32'(irq_id),  32'd2);
    chk("p_busy_svc", 32'(busy),    32'd1);
    tick();
    chk("p_ack_once", 32'(irq_ack), 32'd0);
    chk("p_busy2",    32'(busy),    32'd1);
    ERet = 1'b1;
    tick();
    ERet = 1'b0;
    chk("p_busy_idle", 32'(busy), 32'd0);
    tick();
    chk("p_no_rearb", 32'(ExtIRQ), 32'd0);

    // ---- all sources held, round-robin order -----------------------------
    irq_req = '0;
    do_reset();
    irq_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ext("rr_ext", 4);
      chk("rr_id", 32'(irq_id), 32'(exp_order[g]));
      ExcAck = 1'b1;
      ERet   = 1'b1;             // ERet alongside ExcAck in REQ is ignored
      tick();
      ExcAck = 1'b0;
      ERet   = 1'b0;
      chk("rr_ack", 32'(irq_ack), 32'(4'b0001 << exp_order[g]));
      chk("rr_svc", 32'(busy),    32'd1);
      tick();
      ERet = 1'b1;
      tick();
      ERet = 1'b0;
      chk("rr_ret", 32'(busy), 32'd0);
    end

    // ---- request during SERVICE waits for ERet ----------------------------
    irq_req = '0;
    do_reset();
    irq_req = 4'b0001;
    tick();
    irq_req = '0;
    tick();
    chk("s_ext0", 32'(ExtIRQ), 32'd1);
    ExcAck = 1'b1;
    tick();
    ExcAck = 1'b0;
    irq_req = 4'b0010;
    tick();
    irq_req = '0;
    chk("s_no_ext1", 32'(ExtIRQ), 32'd0);
    tick();
    chk("s_no_ext2", 32'(ExtIRQ), 32'd0);
    tick();
    chk("s_no_ext3", 32'(ExtIRQ), 32'd0);
    ERet = 1'b1;
    tick();
    ERet = 1'b0;
    chk("s_ext_ret", 32'(ExtIRQ), 32'd0);
    chk("s_idle",    32'(busy),   32'd0);
    tick();
    chk("s_ext_new", 32'(ExtIRQ), 32'd1);
    chk("s_id_new",  32'(irq_id), 32'd1);

    // ---- reset during SERVICE drops everything ----------------------------
    irq_req = '0;
    do_reset();
    irq_req = 4'b0001;
    tick();
    irq_req = '0;
    tick();
    ExcAck = 1'b1;
    tick();
    ExcAck = 1'b0;
    irq_req = 4'b1000;
    tick();
    irq_req = '0;
    chk("r_in_svc", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("r_ext",  32'(ExtIRQ),  32'd0);
    chk("r_ack",  32'(irq_ack), 32'd0);
    chk("r_busy", 32'(busy),    32'd0);
    chk("r_id",   32'(irq_id),  32'd0);
    tick();
    chk("r_ack2", 32'(irq_ack), 32'd0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    chk("r_stay_ext",  32'(ExtIRQ), 32'd0);
    chk("r_stay_busy", 32'(busy),   32'd0);

`ifdef IRQ_ARBITER_MASK_EN
    // ---- mask blocks arbitration until cleared ----------------------------
    reset = 1'b0;
    tick();
    reset   = 1'b1;
    irq_req = 4'b0001;
    tick();
    tick();
    tick();
    chk("m_rst_val", 32'(mask),   32'hF);
    chk("m_blocked", 32'(ExtIRQ), 32'd0);
    mask_we    = 1'b1;
    mask_wdata = 4'b1110;
    tick();
    mask_we = 1'b0;
    chk("m_written", 32'(mask),   32'hE);
    tick();
    chk("m_ext", 32'(ExtIRQ), 32'd1);
    chk("m_id",  32'(irq_id), 32'd0);
    irq_req = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
